// File: rtl/dds_wave_gen.sv
// -----------------------------------------------------------------------------
// dds_wave_gen
//
// Phase-accumulator waveform generator. A frequency word is registered, held
// as "pending" while it differs from the word in use, and then loaded either
// immediately or at the next phase wrap, so the phase never jumps. The
// accumulator MSBs are mapped to sawtooth, square, triangle or a midscale
// constant. A sync pulse marks the first sample of every period.
//
// Ports:
//   clk           system clock (single domain)
//   rst           asynchronous, active-high reset
//   en            accumulator / sample pipeline advance enable
//   Fword         requested frequency word (quasi-static)
//   upd_mode      0: apply new word at next phase wrap, 1: apply immediately
//   wave_sel      0 saw, 1 square, 2 triangle, 3 midscale
//   wave_out      output sample
//   wave_valid    wave_out carries a new sample this cycle
//   sync          pulse with the first sample after a phase wrap
//   fword_active  frequency word currently used by the accumulator
// -----------------------------------------------------------------------------
module dds_wave_gen #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] Fword,
    input  logic               upd_mode,
    input  logic [1:0]         wave_sel,
    output logic [OUT_W-1:0]   wave_out,
    output logic               wave_valid,
    output logic               sync,
    output logic [PHASE_W-1:0] fword_active
);

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_MID    = 2'd3
    } wave_e;

    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0] fword_q;
    logic [PHASE_W-1:0] fword_pend;
    logic               pending;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_next;
    logic               wrap;
    logic               wrap_q;
    logic               apply;
    logic [OUT_W-1:0]   sample_next;
    logic [OUT_W-1:0]   tri_bits;

    // A zero word never wraps, so it must not wait for a wrap to be replaced.
    assign apply = pending && (upd_mode || (fword_active == '0) || wrap_q);

    // -------------------------------------------------------------------------
    // Frequency word capture, pending tracking and apply. Runs regardless of en.
    // -------------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fword_q      <= '0;
            fword_pend   <= '0;
            pending      <= 1'b0;
            fword_active <= '0;
        end else begin
            fword_q <= Fword;
            if (apply) begin
                fword_active <= fword_pend;
                pending      <= 1'b0;
            end else if (fword_q != fword_active) begin
                // Latest request overwrites any older pending word.
                pending    <= 1'b1;
                fword_pend <= fword_q;
            end else begin
                // Request returned to the active word before it was applied.
                pending <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Phase accumulator. Uses the word in use before this edge's apply.
    // -------------------------------------------------------------------------
    assign {wrap, acc_next} = {1'b0, acc} + {1'b0, fword_active};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            wrap_q <= 1'b0;
        end else if (en) begin
            acc    <= acc_next;
            wrap_q <= wrap;
        end
    end

    // -------------------------------------------------------------------------
    // Sample mapping from the accumulator MSBs.
    // -------------------------------------------------------------------------
    assign tri_bits = acc[PHASE_W-2 -: OUT_W];

    // NOTE: sample_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sample_next = MIDSCALE;
        case (wave_e'(wave_sel))
            WAVE_SAW:    sample_next = acc[PHASE_W-1 -: OUT_W];
            WAVE_SQUARE: sample_next = acc[PHASE_W-1] ? '1 : '0;
            WAVE_TRI:    sample_next = acc[PHASE_W-1] ? ~tri_bits : tri_bits;
            WAVE_MID:    sample_next = MIDSCALE;
            default:     sample_next = MIDSCALE;
        endcase
    end

    // wrap_q marks that acc holds a freshly wrapped phase; it is held while
    // en is low, so the first post-wrap sample still carries sync on resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_out   <= '0;
            wave_valid <= 1'b0;
            sync       <= 1'b0;
        end else if (en) begin
            wave_out   <= sample_next;
            wave_valid <= 1'b1;
            sync       <= wrap_q;
        end else begin
            wave_valid <= 1'b0;
            sync       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_wave_gen
//
// Self-checking bench for dds_wave_gen. A behavioural model tracks the phase
// as an integer modulo 2^24 and derives each waveform arithmetically; a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios add literal expectations (sync intervals, update
// timing, waveform extremes) followed by a randomized stretch.
// -----------------------------------------------------------------------------
module tb_dds_wave_gen;

    localparam int  PHASE_W = 24;
    localparam int  OUT_W   = 10;
    localparam longint MODULUS = 64'd1 << PHASE_W;
    localparam int  HALF    = 1 << (PHASE_W - 1);

    logic               clk;
    logic               rst;
    logic               en;
    logic [PHASE_W-1:0] Fword;
    logic               upd_mode;
    logic [1:0]         wave_sel;
    logic [OUT_W-1:0]   wave_out;
    logic               wave_valid;
    logic               sync;
    logic [PHASE_W-1:0] fword_active;

    dds_wave_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .Fword        (Fword),
        .upd_mode     (upd_mode),
        .wave_sel     (wave_sel),
        .wave_out     (wave_out),
        .wave_valid   (wave_valid),
        .sync         (sync),
        .fword_active (fword_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Behavioural model: integer phase, words tracked as plain values.
    // -------------------------------------------------------------------------
    function automatic int shape(input int phase, input int sel);
        int t;
        t = (phase / 8192) % 1024;
        case (sel)
            0:       return phase / 16384;
            1:       return (phase >= HALF) ? 1023 : 0;
            2:       return (phase >= HALF) ? 1023 - t : t;
            default: return 512;
        endcase
    endfunction

    int  m_req;      // word seen at the input register
    int  m_want;     // latest word waiting to be applied
    bit  m_waiting;
    int  m_act;
    int  m_phase;
    bit  m_wrapped;
    int  m_out;
    bit  m_valid;
    bit  m_sync;

    always @(posedge clk or posedge rst) begin
        longint sum;
        if (rst) begin
            m_req <= 0; m_want <= 0; m_waiting <= 0; m_act <= 0;
            m_phase <= 0; m_wrapped <= 0; m_out <= 0; m_valid <= 0; m_sync <= 0;
        end else begin
            m_req <= int'(Fword);
            if (m_waiting && (upd_mode || m_act == 0 || m_wrapped)) begin
                m_act     <= m_want;
                m_waiting <= 0;
            end else begin
                m_waiting <= (m_req != m_act);
                if (m_req != m_act) m_want <= m_req;
            end
            if (en) begin
                sum       = longint'(m_phase) + longint'(m_act);
                m_phase   <= int'(sum % MODULUS);
                m_wrapped <= (sum >= MODULUS);
                m_out     <= shape(m_phase, int'(wave_sel));
                m_valid   <= 1;
                m_sync    <= m_wrapped;
            end else begin
                m_valid <= 0;
                m_sync  <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("wave_out",     64'(wave_out),     64'(m_out));
            check("wave_valid",   64'(wave_valid),   64'(m_valid));
            check("sync",         64'(sync),         64'(m_sync));
            check("fword_active", 64'(fword_active), 64'(m_act));
        end
    end

    // Watches that a word overwritten while pending is never applied.
    bit watch_skip = 0;
    bit skipped_seen = 0;
    always @(negedge clk) if (watch_skip && fword_active == 24'hA3D7) skipped_seen <= 1;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic wait_sync(output int at);
        bit found;
        found = 0;
        at = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (sync === 1'b1) begin
                at = cyc;
                found = 1;
            end
        end
        if (!found) check("sync_timeout", 64'd0, 64'd1);
    endtask

    task automatic measure_period(input string name, input int lo, input int hi);
        int a, b;
        wait_sync(a);
        wait_sync(b);
        check_range(name, b - a, lo, hi);
    endtask

    task automatic settle(input logic [PHASE_W-1:0] w);
        int a;
        upd_mode = 1'b1;
        Fword    = w;
        wait_sync(a);
        wait_sync(a);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int a;
        logic [OUT_W-1:0]   prev_out;
        logic [PHASE_W-1:0] prev_act;
        bit found, hi_seen, lo_seen;
        int tri_max, tri_min;

        rst = 1'b1; en = 1'b1; Fword = 24'h0051EB; upd_mode = 1'b0; wave_sel = 2'd0;

        // Reset and startup
        repeat (3) @(negedge clk);
        check("rst_wave_out",     64'(wave_out),     64'd0);
        check("rst_wave_valid",   64'(wave_valid),   64'd0);
        check("rst_sync",         64'(sync),         64'd0);
        check("rst_fword_active", 64'(fword_active), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("startup_edge2_active", 64'(fword_active), 64'd0);
        @(negedge clk);
        check("startup_edge3_active", 64'(fword_active), 64'h51EB);
        measure_period("period_51EB", 800, 801);

        // Immediate update mid-period
        repeat (100) @(negedge clk);
        upd_mode = 1'b1;
        Fword    = 24'h00A3D7;
        repeat (2) @(negedge clk);
        check("imm_edge_k1_active", 64'(fword_active), 64'h51EB);
        @(negedge clk);
        check("imm_edge_k2_active", 64'(fword_active), 64'hA3D7);
        wait_sync(a);
        measure_period("period_imm_A3D7", 400, 401);

        // Wrap-aligned update
        settle(24'h0051EB);
        upd_mode = 1'b0;
        repeat (100) @(negedge clk);
        Fword = 24'h00A3D7;
        found = 0;
        prev_act = fword_active;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (sync === 1'b1) begin
                found = 1;
                check("wrap_before_active", 64'(prev_act),     64'h51EB);
                check("wrap_after_active",  64'(fword_active), 64'hA3D7);
            end
            prev_act = fword_active;
        end
        if (!found) check("wrap_sync_timeout", 64'd0, 64'd1);
        measure_period("period_wrap_A3D7", 400, 401);

        // Overwrite while pending
        settle(24'h0051EB);
        upd_mode   = 1'b0;
        watch_skip = 1;
        repeat (50) @(negedge clk);
        Fword = 24'h00A3D7;
        repeat (100) @(negedge clk);
        Fword = 24'h00F5C2;
        wait_sync(a);
        check("overwrite_active", 64'(fword_active), 64'hF5C2);
        measure_period("period_F5C2", 266, 267);
        watch_skip = 0;
        check("overwrite_skipped_word", 64'(skipped_seen), 64'd0);

        // Waveform mapping with Fword = 0x4000 (1024 samples per period)
        upd_mode = 1'b1;
        Fword    = 24'h004000;
        wave_sel = 2'd0;
        repeat (1100) @(negedge clk);
        prev_out = wave_out;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            check("saw_step", 64'(wave_out - prev_out), 64'd1);
            prev_out = wave_out;
        end
        wave_sel = 2'd1;
        hi_seen = 0; lo_seen = 0;
        repeat (4) @(negedge clk);
        for (int n = 0; n < 1100; n++) begin
            @(negedge clk);
            if (wave_out == 10'h3FF) hi_seen = 1;
            if (wave_out == 10'h000) lo_seen = 1;
        end
        check("square_both_levels", 64'({hi_seen, lo_seen}), 64'd3);
        wave_sel = 2'd2;
        tri_max = 0; tri_min = 1023;
        repeat (4) @(negedge clk);
        for (int n = 0; n < 1100; n++) begin
            @(negedge clk);
            if (int'(wave_out) > tri_max) tri_max = int'(wave_out);
            if (int'(wave_out) < tri_min) tri_min = int'(wave_out);
        end
        check("tri_peak", 64'(tri_max), 64'h3FF);
        check("tri_floor", 64'(tri_min), 64'd0);
        wave_sel = 2'd3;
        repeat (3) @(negedge clk);
        check("midscale", 64'(wave_out), 64'h200);

        // Enable gating
        wave_sel = 2'd0;
        repeat (37) @(negedge clk);
        prev_out = wave_out;
        en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("gate_hold", 64'(wave_out), 64'(prev_out));
            check("gate_valid", 64'(wave_valid), 64'd0);
            check("gate_sync", 64'(sync), 64'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("gate_resume_step", 64'(wave_out - prev_out), 64'd1);

        // Asynchronous reset mid-period
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wave_out",     64'(wave_out),     64'd0);
        check("async_rst_wave_valid",   64'(wave_valid),   64'd0);
        check("async_rst_sync",         64'(sync),         64'd0);
        check("async_rst_fword_active", 64'(fword_active), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized stretch, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) Fword = 24'($urandom_range(24'h008000, 24'hFFFFFF));
            if ($urandom_range(0, 49) == 0) upd_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) wave_sel = 2'($urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
